i2c_master_ctrl: RTL and testbench

Single-byte I2C master controller that sequences a complete bus transaction on the open-drain SCL/SDA pads. It runs START, address+R/W, ACK, one data byte, ACK/NACK and STOP. It generates SCL with the team's standard SCL timing: 100 clk per SCL period at defaults, i.e. SCL toggles every 50 clk. It sits between the register/host interface and the pad cells; the host issues one-shot byte transfers and polls `busy` or waits for `done`.

---
 rtl/i2c_master_ctrl_if.sv | 25 ++
 rtl/i2c_master_ctrl.sv | 157 +++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/i2c_master_ctrl_if.sv
// Host/pad-side signal bundle for the single-byte I2C master.
// master: the controller itself; slave: whoever drives requests and the SDA pad level.
interface i2c_master_ctrl_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       sda_in;
    logic       scl_oe;
    logic       sda_oe;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       ack_err;

    modport master (
        input  start, rw, addr, wdata, sda_in,
        output scl_oe, sda_oe, rdata, busy, done, ack_err
    );

    modport slave (
        output start, rw, addr, wdata, sda_in,
        input  scl_oe, sda_oe, rdata, busy, done, ack_err
    );
endinterface

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, addr+R/W, ACK, one data byte, ACK/NACK, STOP.
// Each bit-slot is four quarters of QTR clk; all pad and status outputs are registered.
module i2c_master_ctrl #(
    parameter int QTR = 25
) (
    input  logic              clk,
    input  logic              rst_,
    i2c_master_ctrl_if.master bus
);
    localparam int QW = $clog2(QTR);

    // state | meaning
    // IDLE  | lines released, waiting for start
    // START | Q0-Q1 both released, Q2-Q3 SDA low with SCL released
    // ADDR  | eight slots of {addr,rw}, MSB first
    // ACK1  | slave acknowledges the address
    // DATA  | eight slots of write data or read sampling
    // ACK2  | slave ACK on write, master NACK on read
    // STOP  | SCL released in Q2, SDA released in Q3
    typedef enum logic [2:0] {IDLE, START, ADDR, ACK1, DATA, ACK2, STOP} state_t;

    state_t        state;
    logic [QW-1:0] qcnt;
    logic [1:0]    qidx;
    logic [2:0]    bit_cnt;
    logic [7:0]    tx_sh;
    logic [7:0]    rx_sh;
    logic [7:0]    wdata_q;
    logic          rw_q;
    logic          scl_oe;
    logic          sda_oe;
    logic [7:0]    rdata;
    logic          busy;
    logic          done;
    logic          ack_err;
    logic          q_end;

    assign q_end = (qcnt == '0);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state   <= IDLE;
            qcnt    <= '0;
            qidx    <= '0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            scl_oe  <= 1'b0;
            sda_oe  <= 1'b0;
            rdata   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                scl_oe <= 1'b0;
                sda_oe <= 1'b0;
                // The done cycle still belongs to the finished transfer, so a start there is dropped.
                if (bus.start && !done) begin
                    tx_sh   <= {bus.addr, bus.rw};
                    wdata_q <= bus.wdata;
                    rw_q    <= bus.rw;
                    ack_err <= 1'b0;
                    busy    <= 1'b1;
                    state   <= START;
                    qcnt    <= QW'(QTR - 1);
                    qidx    <= 2'd0;
                    bit_cnt <= 3'd0;
                end
            end else if (!q_end) begin
                qcnt <= qcnt - 1'b1;
            end else begin
                qcnt <= QW'(QTR - 1);
                qidx <= qidx + 2'd1;
                case (state)
                    START: begin
                        if (qidx == 2'd1) sda_oe <= 1'b1;
                        if (qidx == 2'd3) begin
                            state  <= ADDR;
                            scl_oe <= 1'b1;
                            sda_oe <= ~tx_sh[7];
                        end
                    end
                    STOP: begin
                        if (qidx == 2'd1) scl_oe <= 1'b0;
                        if (qidx == 2'd2) sda_oe <= 1'b0;
                        if (qidx == 2'd3) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                        if (qidx == 2'd1) scl_oe <= 1'b0;
                        if (qidx == 2'd2) begin
                            if ((state == ACK1 || (state == ACK2 && !rw_q)) && bus.sda_in)
                                ack_err <= 1'b1;
                            if (state == DATA && rw_q)
                                rx_sh <= {rx_sh[6:0], bus.sda_in};
                        end
                        if (qidx == 2'd3) begin
                            scl_oe <= 1'b1;
                            case (state)
                                ADDR: begin
                                    if (bit_cnt == 3'd7) begin
                                        state  <= ACK1;
                                        sda_oe <= 1'b0;
                                    end else begin
                                        bit_cnt <= bit_cnt + 3'd1;
                                        tx_sh   <= {tx_sh[6:0], 1'b0};
                                        sda_oe  <= ~tx_sh[6];
                                    end
                                end
                                ACK1: begin
                                    if (ack_err) begin
                                        state  <= STOP;
                                        sda_oe <= 1'b1;
                                    end else begin
                                        state   <= DATA;
                                        bit_cnt <= 3'd0;
                                        tx_sh   <= wdata_q;
                                        sda_oe  <= ~rw_q & ~wdata_q[7];
                                    end
                                end
                                DATA: begin
                                    if (bit_cnt == 3'd7) begin
                                        state  <= ACK2;
                                        sda_oe <= 1'b0;
                                        if (rw_q) rdata <= rx_sh;
                                    end else begin
                                        bit_cnt <= bit_cnt + 3'd1;
                                        tx_sh   <= {tx_sh[6:0], 1'b0};
                                        sda_oe  <= ~rw_q & ~tx_sh[6];
                                    end
                                end
                                default: begin
                                    state  <= STOP;
                                    sda_oe <= 1'b1;
                                end
                            endcase
                        end
                    end
                endcase
            end
        end
    end

    assign bus.scl_oe  = scl_oe;
    assign bus.sda_oe  = sda_oe;
    assign bus.rdata   = rdata;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.ack_err = ack_err;
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: a bit-level I2C slave/monitor on the pads and a
// transaction-level model of the expected SDA bit stream, status and done timing.
module tb_i2c_master_ctrl;
    localparam int QTR = 2;

    logic clk;
    logic rst_;
    i2c_master_ctrl_if bus ();

    i2c_master_ctrl #(.QTR(QTR)) dut (.clk(clk), .rst_(rst_), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          compared   = 0;
    int          mismatched = 0;
    logic [7:0]  exp_rdata;
    logic        s_aa, s_ad, s_rw;
    logic [7:0]  s_rb;
    logic        slave_pull;
    logic [31:0] mon_bits;
    int          mon_n;

    // Open-drain line: low if either side pulls.
    assign bus.sda_in = ~(bus.sda_oe | slave_pull);

    // Slave + monitor: resyncs on START, counts SCL falls to place itself in the frame,
    // and records the line level at every SCL rise.
    initial begin : slave
        logic ps, pd;
        int   f;
        ps = 1'b0; pd = 1'b0; f = 0;
        slave_pull = 1'b0; mon_bits = '0; mon_n = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_) begin
                f = 0;
                slave_pull = 1'b0;
            end else begin
                if (bus.sda_oe && !pd && !bus.scl_oe && !ps) begin
                    f = 0; mon_bits = '0; mon_n = 0;
                end
                if (bus.scl_oe && !ps) begin
                    f++;
                    slave_pull = 1'b0;
                    if (f == 9) slave_pull = s_aa;
                    else if (s_aa && s_rw && f >= 10 && f <= 17) slave_pull = ~s_rb[3'(17 - f)];
                    else if (s_aa && !s_rw && f == 18) slave_pull = s_ad;
                end
                if (!bus.scl_oe && ps) begin
                    mon_bits = {mon_bits[30:0], bus.sda_in};
                    mon_n++;
                end
            end
            ps = bus.scl_oe;
            pd = bus.sda_oe;
        end
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                           input logic aa, input logic ad, input logic [7:0] rb,
                           input int inject_at, input bit start_on_done, input string tag);
        logic [31:0] eb;
        int          en, ed, n;
        logic        ee, got;
        logic [7:0]  er;
        eb = {24'd0, a, r};
        en = 8;
        eb = {eb[30:0], ~aa};
        en++;
        if (!aa) begin
            ed = 1 + 44 * QTR; ee = 1'b1; er = exp_rdata;
        end else begin
            eb = {eb[23:0], (r ? rb : wd)};
            en += 8;
            eb = {eb[30:0], (r ? 1'b1 : ~ad)};
            en++;
            ed = 1 + 80 * QTR; ee = !r && !ad; er = r ? rb : exp_rdata;
        end
        eb = {eb[30:0], 1'b0};
        en++;

        s_aa = aa; s_ad = ad; s_rw = r; s_rb = rb;
        @(negedge clk);
        bus.start = 1'b1; bus.addr = a; bus.rw = r; bus.wdata = wd;
        n = 0; got = 1'b0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                bus.start = 1'b0;
                chk(32'(bus.busy), 32'd1, {tag, ".busy_rise"});
            end
            if (n == inject_at) begin
                bus.start = 1'b1; bus.addr = ~a; bus.rw = ~r; bus.wdata = ~wd;
            end
            if (n == inject_at + 1) bus.start = 1'b0;
            if (bus.done) got = 1'b1;
        end
        chk(32'(n), 32'(ed), {tag, ".done_cycle"});
        chk(32'(bus.busy), 32'd0, {tag, ".busy_at_done"});
        chk(32'(bus.ack_err), 32'(ee), {tag, ".ack_err"});
        chk(32'(bus.rdata), 32'(er), {tag, ".rdata"});
        chk(32'(mon_n), 32'(en), {tag, ".scl_rises"});
        chk(mon_bits, eb, {tag, ".sda_bits"});
        exp_rdata = er;
        if (start_on_done) bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk(32'(bus.done), 32'd0, {tag, ".done_width"});
        chk(32'(bus.busy), 32'd0, {tag, ".idle_after"});
    endtask

    initial begin : main
        int n;
        bus.start = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.wdata = '0;
        s_aa = 1'b0; s_ad = 1'b0; s_rw = 1'b0; s_rb = '0;
        exp_rdata = 8'h00;
        rst_ = 1'b0;
        repeat (3) @(negedge clk);
        chk(32'(bus.scl_oe), 32'd0, "reset.scl_oe");
        chk(32'(bus.sda_oe), 32'd0, "reset.sda_oe");
        chk(32'(bus.rdata), 32'd0, "reset.rdata");
        chk(32'(bus.busy), 32'd0, "reset.busy");
        chk(32'(bus.done), 32'd0, "reset.done");
        chk(32'(bus.ack_err), 32'd0, "reset.ack_err");
        rst_ = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, -10, 1'b0, "write");
        run_txn(7'h12, 1'b0, 8'h81, 1'b0, 1'b1, 8'h00, -10, 1'b1, "addr_nack");
        run_txn(7'h3B, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, -10, 1'b0, "read");
        run_txn(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 20, 1'b0, "start_in_addr");
        run_txn(7'h44, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, -10, 1'b0, "data_nack");

        // Reset during the Q1 of the first DATA slot, while both lines are pulled.
        s_aa = 1'b1; s_ad = 1'b1; s_rw = 1'b0; s_rb = 8'h00;
        @(negedge clk);
        bus.start = 1'b1; bus.addr = 7'h21; bus.rw = 1'b0; bus.wdata = 8'h3C;
        n = 0;
        while (n < 10 * 4 * QTR + 3) begin
            @(negedge clk);
            n++;
            bus.start = 1'b0;
        end
        rst_ = 1'b0;
        #1;
        chk(32'(bus.scl_oe), 32'd0, "midreset.scl_oe");
        chk(32'(bus.sda_oe), 32'd0, "midreset.sda_oe");
        chk(32'(bus.busy), 32'd0, "midreset.busy");
        chk(32'(bus.done), 32'd0, "midreset.done");
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        exp_rdata = 8'h00;
        chk(32'(bus.rdata), 32'd0, "midreset.rdata");
        run_txn(7'h2A, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00, -10, 1'b0, "after_reset");

        for (int i = 0; i < 6; i++) begin
            run_txn(7'($urandom), 1'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                    8'($urandom), -10, 1'b0, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
